// File: rtl/riscv_dmem.sv
// riscv_dmem: data memory with byte-enabled stores, extended loads, io_out/cycle registers and sticky store-fault capture
module riscv_dmem #(
  parameter int MEM_WORDS = 64,
  parameter logic [31:0] IO_OUT_ADDR = 32'hFFFF_0000,
  parameter logic [31:0] CYCLE_ADDR = 32'hFFFF_0004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [31:0] io_out,
  output logic        fault,
  output logic [31:0] fault_addr
);
  localparam int IW = $clog2(MEM_WORDS);
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] cycle;
  logic [31:0] word_addr, wdata, src, lane_sel;
  logic [IW-1:0] idx;
  logic [7:0] b;
  logic [15:0] h;
  logic [3:0] be;
  logic is_io, is_cyc, in_ram, valid_f3, misaligned, st, st_fault, st_ok;
  always_comb begin
    word_addr = {addr[31:2], 2'b00};
    idx = addr[IW+1:2];
    is_io = word_addr == IO_OUT_ADDR;
    is_cyc = word_addr == CYCLE_ADDR;
    in_ram = {2'b00, addr[31:2]} < 32'(MEM_WORDS);
    valid_f3 = funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010;
    misaligned = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && |addr[1:0]);
    st = we && valid_f3;
    st_fault = st && (misaligned || !(is_io || is_cyc || in_ram));
    st_ok = st && !st_fault;
    be = funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
         funct3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = funct3[1:0] == 2'b00 ? {4{wd[7:0]}} :
            funct3[1:0] == 2'b01 ? {2{wd[15:0]}} : wd;
    src = is_io ? io_out : is_cyc ? cycle : in_ram ? mem[idx] : 32'h0;
    lane_sel = src >> {addr[1:0], 3'b000};
    b = lane_sel[7:0];
    h = addr[1] ? src[31:16] : src[15:0];
    rd = funct3 == 3'b000 ? {{24{b[7]}}, b} :
         funct3 == 3'b100 ? {24'h0, b} :
         funct3 == 3'b001 ? {{16{h[15]}}, h} :
         funct3 == 3'b101 ? {16'h0, h} : src;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (st_ok && !is_io && !is_cyc && in_ram && be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_out <= 32'h0;
      fault <= 1'b0;
      fault_addr <= 32'h0;
      cycle <= 32'h0;
    end else begin
      cycle <= cycle + 32'd1;
      for (int i = 0; i < 4; i++)
        if (st_ok && is_io && be[i]) io_out[i*8 +: 8] <= wdata[i*8 +: 8];
      if (st_fault && !fault) begin
        fault <= 1'b1;
        fault_addr <= addr;
      end
    end
  end
endmodule

// File: doc/riscv_dmem.md
Name: riscv_dmem

Overview:
- Data-memory responder for the pipelined CPU's memory-stage interface.
- Accepts the CPU's write enable, address, store data and funct3.
- Performs byte/half/word stores with synchronous byte-enabled writes.
- Returns combinational load data, sign- or zero-extended per funct3.
- Also hosts two memory-mapped registers (output port, free-running cycle counter) and a sticky store-fault capture.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the RAM array; word index is addr[31:2], valid when < MEM_WORDS.
- IO_OUT_ADDR, 32'hFFFF_0000, word address of the writable output register.
- CYCLE_ADDR, 32'hFFFF_0004, word address of the read-only cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- we  input  1  store request from the CPU memory stage.
- funct3  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- addr  input  32  byte address (CPU ALU result).
- wd  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rd  output  32  load data, extended per funct3.
- io_out  output  32  memory-mapped output register.
- fault  output  1  sticky store-fault flag.
- fault_addr  output  32  address of the first faulting store since reset.

Behaviour:
- Reset (async, active-high): io_out=0, fault=0, fault_addr=0, cycle counter=0. RAM contents are not reset. rd is combinational, so it is not a register.
- Cycle counter: increments by 1 every clk edge while reset is low; wraps 32'hFFFF_FFFF -> 0.
- Store alignment: half needs addr[0]==0; word needs addr[1:0]==00; byte is always aligned.
- Store byte lanes:
  - sb writes lane addr[1:0] with wd[7:0].
  - sh writes lanes {addr[1],0} and {addr[1],1} with wd[15:0].
  - sw writes all four lanes.
  - Unwritten lanes keep their value.
- Store target decode on the word address (addr with [1:0] cleared):
  - == IO_OUT_ADDR: lane-merge into io_out.
  - == CYCLE_ADDR: no effect, no fault.
  - word index < MEM_WORDS: lane-merge into RAM.
  - anything else: faulting store.
- Store fault:
  - Causes: we=1 with a misaligned address, or an out-of-range address. Nothing is written.
  - If fault was 0: set fault=1 and capture fault_addr=addr on that edge.
  - If fault was already 1: fault_addr holds.
  - fault clears only on reset.
- Store with funct3 in {011,1xx}: ignored, no write, no fault.
- Read path (purely combinational, evaluated every cycle regardless of we):
  - Source word: RAM[index] if in range; io_out at IO_OUT_ADDR; cycle counter at CYCLE_ADDR; otherwise 0.
  - lb/lbu select byte addr[1:0]; lb sign-extends bit 7, lbu zero-extends.
  - lh/lhu select half addr[1]; sign- or zero-extend from bit 15. Misaligned halves still use addr[1] (no fault on loads).
  - lw and reserved funct3 (011,110,111) return the whole word.
- Write/read timing: a store is visible on rd from the cycle after the capturing edge. A read of the same address in the store cycle returns the old data (no bypass).
- Reset mid-store: reset wins. Registers clear; the RAM write on that edge is not guaranteed.
- Widths: all arithmetic is 32-bit. Address bits above the index range matter only for the MEM_WORDS range check and the register decode.

Test Plan:
- Reset, then sw 0xDEADBEEF @0x08; next cycle lw @0x08 -> rd=0xDEADBEEF; same-cycle read during the store -> old value.
- sb 0x80 @0x0D over word 0x11223344 -> word 0x11228044; lb @0x0D -> 0xFFFFFF80; lbu @0x0D -> 0x00000080.
- sh 0xA5A5 @0x12 -> upper half updated; lh @0x12 -> 0xFFFFA5A5; lhu @0x12 -> 0x0000A5A5; lower half unchanged.
- sh @0x21 -> no write, fault=1, fault_addr=0x21. Then sw @0x1000 (out of range) -> fault_addr stays 0x21. Reset -> fault=0, fault_addr=0.
- sw 0x12345678 @IO_OUT_ADDR -> io_out=0x12345678. sb 0xFF @IO_OUT_ADDR+3 -> io_out=0xFF345678. sw @CYCLE_ADDR -> no change, no fault.
- lw @CYCLE_ADDR on two reads N cycles apart -> values differ by N. Force the counter to 0xFFFFFFFF -> next cycle reads 0.
